pll_reset_sequencer: RTL and testbench

//  Bring-up controller for the shared 25.175 MHz PLL. Sits in the board top between pll_25mhz and the VGA core.

---
 rtl/pll_reset_sequencer_pkg.sv | 11 +
 rtl/pll_reset_sequencer_bit_sync.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 110 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL bring-up sequencer: FSM state encoding.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } pll_state_t;

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Reset-to-zero flop chain bringing a single asynchronous bit into the clk domain.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up controller: qualifies the synchronised lock flag, releases the
// VGA core reset after stable lock, and re-asserts it on lock loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned STABLE_CYCLES     = 12000,
    parameter int unsigned FAULT_HOLD_CYCLES = 1200,
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned LOSS_W            = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked_async,
    output logic              core_rst_n,
    output logic              ready,
    output logic [1:0]        state,
    output logic [LOSS_W-1:0] lock_loss_count,
    output logic [4:0]        led
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAULT_LAST  = CNT_W'(FAULT_HOLD_CYCLES - 1);
    localparam int unsigned      LED_LOSS_W  = (LOSS_W < 4) ? LOSS_W : 4;

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || FAULT_HOLD_CYCLES < 1) begin : g_bad_params
        $error("pll_reset_sequencer: invalid stage or cycle parameter");
    end

    pll_state_t       st;
    logic [CNT_W-1:0] cnt;
    logic             lk;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked_async),
        .q     (lk)
    );

    // core_rst_n/ready are assigned alongside every transition into or out of
    // RUN so they track the registered state without a decode stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st              <= ST_WAIT_LOCK;
            cnt             <= '0;
            lock_loss_count <= '0;
            core_rst_n      <= 1'b0;
            ready           <= 1'b0;
        end else begin
            unique case (st)
                ST_WAIT_LOCK: begin
                    cnt <= '0;
                    if (lk) begin
                        st <= ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    if (!lk) begin
                        st  <= ST_WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        st         <= ST_RUN;
                        cnt        <= '0;
                        core_rst_n <= 1'b1;
                        ready      <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt <= '0;
                    if (!lk) begin
                        st         <= ST_FAULT;
                        core_rst_n <= 1'b0;
                        ready      <= 1'b0;
                        if (lock_loss_count != '1) begin
                            lock_loss_count <= lock_loss_count + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (cnt == FAULT_LAST) begin
                        st  <= ST_WAIT_LOCK;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    st         <= ST_WAIT_LOCK;
                    cnt        <= '0;
                    core_rst_n <= 1'b0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

    always_comb begin
        led                   = '0;
        led[4]                = ready;
        led[LED_LOSS_W-1:0]   = lock_loss_count[LED_LOSS_W-1:0];
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer with short qualification timings.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int unsigned SYNC_STAGES       = 2;
    localparam int unsigned STABLE_CYCLES     = 8;
    localparam int unsigned FAULT_HOLD_CYCLES = 4;
    localparam int unsigned CNT_W             = 16;
    localparam int unsigned LOSS_W            = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pll_locked_async;
    logic        core_rst_n;
    logic        ready;
    logic [1:0]  state;
    logic [3:0]  lock_loss_count;
    logic [4:0]  led;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC_STAGES),
        .STABLE_CYCLES     (STABLE_CYCLES),
        .FAULT_HOLD_CYCLES (FAULT_HOLD_CYCLES),
        .CNT_W             (CNT_W),
        .LOSS_W            (LOSS_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pll_locked_async (pll_locked_async),
        .core_rst_n       (core_rst_n),
        .ready            (ready),
        .state            (state),
        .lock_loss_count  (lock_loss_count),
        .led              (led)
    );

    // Expected vector layout: {state, core_rst_n, ready, loss[3:0], led[4:0]}
    typedef struct {
        string       tag;
        logic [12:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [3:0]  exp_loss = 4'd0;

    task automatic push_exp(input string tag, input pll_state_t st, input logic [3:0] loss);
        exp_t e;
        logic r;
        r     = (st == ST_RUN);
        e.tag = tag;
        e.val = {st, r, r, loss, r, loss};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [12:0] obs;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed no queued expectation, expected one");
            return;
        end
        e   = sb.pop_front();
        obs = {state, core_rst_n, ready, lock_loss_count, led};
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed state=%0d core_rst_n=%b ready=%b loss=%h led=%b, expected state=%0d core_rst_n=%b ready=%b loss=%h led=%b",
                   e.tag, obs[12:11], obs[10], obs[9], obs[8:5], obs[4:0],
                   e.val[12:11], e.val[10], e.val[9], e.val[8:5], e.val[4:0]);
        end
    endtask

    task automatic run(input string tag, input pll_state_t st, input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(tag, st, exp_loss);
            @(posedge clk);
            #1;
            check_out();
        end
    endtask

    task automatic chk_cnt(input string tag, input int unsigned exp_cnt);
        n_checks++;
        assert (dut.cnt === CNT_W'(exp_cnt)) else begin
            n_fail++;
            $error("FAIL %s: observed counter=%0d, expected %0d", tag, dut.cnt, exp_cnt);
        end
    endtask

    initial begin
        // Test 1: reset held with lock high, then release.
        rst_n            = 1'b0;
        pll_locked_async = 1'b1;
        run("t1_in_reset", ST_WAIT_LOCK, 3);
        rst_n = 1'b1;
        run("t1_sync", ST_WAIT_LOCK, 2);
        run("t1_stable", ST_STABLE, 8);
        run("t1_run_edge11", ST_RUN, 2);

        // Test 2: glitch during qualification is not a loss.
        rst_n            = 1'b0;
        pll_locked_async = 1'b0;
        run("t2_reset", ST_WAIT_LOCK, 1);
        rst_n            = 1'b1;
        pll_locked_async = 1'b1;
        run("t2_sync", ST_WAIT_LOCK, 2);
        run("t2_stable_a", ST_STABLE, 5);
        pll_locked_async = 1'b0;
        run("t2_stable_b", ST_STABLE, 1);
        pll_locked_async = 1'b1;
        run("t2_stable_c", ST_STABLE, 1);
        run("t2_glitch_wait", ST_WAIT_LOCK, 1);
        run("t2_requal", ST_STABLE, 8);
        run("t2_run", ST_RUN, 1);

        // Test 3: lock loss in RUN, lock restored immediately during FAULT.
        pll_locked_async = 1'b0;
        run("t3_run_tail", ST_RUN, 2);
        exp_loss = 4'd1;
        run("t3_fault_entry", ST_FAULT, 1);
        pll_locked_async = 1'b1;
        run("t3_fault_hold", ST_FAULT, 3);
        run("t3_fault_exit", ST_WAIT_LOCK, 1);
        run("t3_requal", ST_STABLE, 8);
        run("t3_run", ST_RUN, 1);

        // Test 4: repeated losses saturate the loss counter.
        for (int k = 0; k < 17; k++) begin
            pll_locked_async = 1'b0;
            run("t4_run_tail", ST_RUN, 2);
            exp_loss = (exp_loss == 4'hF) ? 4'hF : exp_loss + 4'd1;
            run("t4_fault_entry", ST_FAULT, 1);
            pll_locked_async = 1'b1;
            run("t4_fault_hold", ST_FAULT, 3);
            run("t4_wait", ST_WAIT_LOCK, 1);
            run("t4_stable", ST_STABLE, 8);
            run("t4_run", ST_RUN, 1);
        end

        // Test 5a: reset while in STABLE.
        pll_locked_async = 1'b0;
        run("t5_run_tail", ST_RUN, 2);
        run("t5_fault", ST_FAULT, 1);
        pll_locked_async = 1'b1;
        run("t5_fault_hold", ST_FAULT, 3);
        run("t5_wait", ST_WAIT_LOCK, 1);
        run("t5_stable", ST_STABLE, 3);
        chk_cnt("t5_cnt_before_reset", 2);
        rst_n    = 1'b0;
        exp_loss = 4'd0;
        run("t5_reset_in_stable", ST_WAIT_LOCK, 1);
        chk_cnt("t5_cnt_after_stable_reset", 0);
        rst_n = 1'b1;
        run("t5_sync", ST_WAIT_LOCK, 2);
        run("t5_requal", ST_STABLE, 8);
        run("t5_run", ST_RUN, 1);

        // Test 5b: reset while in FAULT.
        pll_locked_async = 1'b0;
        run("t5_run_tail_b", ST_RUN, 2);
        exp_loss = 4'd1;
        run("t5_fault_b", ST_FAULT, 2);
        chk_cnt("t5_cnt_in_fault", 1);
        rst_n    = 1'b0;
        exp_loss = 4'd0;
        run("t5_reset_in_fault", ST_WAIT_LOCK, 1);
        chk_cnt("t5_cnt_after_fault_reset", 0);
        rst_n            = 1'b1;
        pll_locked_async = 1'b1;
        run("t5_sync_b", ST_WAIT_LOCK, 2);
        run("t5_requal_b", ST_STABLE, 8);
        run("t5_run_b", ST_RUN, 1);

        // Test 6: lock falls on the terminal-count cycle.
        pll_locked_async = 1'b0;
        run("t6_run_tail", ST_RUN, 2);
        exp_loss = 4'd1;
        run("t6_fault", ST_FAULT, 4);
        run("t6_wait_low", ST_WAIT_LOCK, 2);
        pll_locked_async = 1'b1;
        run("t6_sync", ST_WAIT_LOCK, 2);
        run("t6_stable_a", ST_STABLE, 6);
        pll_locked_async = 1'b0;
        run("t6_stable_b", ST_STABLE, 2);
        chk_cnt("t6_cnt_terminal", STABLE_CYCLES - 1);
        run("t6_abort_to_wait", ST_WAIT_LOCK, 4);
        chk_cnt("t6_cnt_wait", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
